// File: rtl/out_port_fifo.sv
// Output-port FIFO: buffers CPU output-port writes and hands them to a peripheral over valid/ready.
// Optional OUT_PORT_LAST_EN adds last_out, a copy of the most recently accepted write.
module out_port_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         loadOut,
    input  logic [WIDTH-1:0]             bus_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
`ifdef OUT_PORT_LAST_EN
    ,
    output logic [WIDTH-1:0]             last_out
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             overflow_q;
    logic             push;
    logic             pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign count     = count_q;
    assign out_data  = head_q;
    assign overflow  = overflow_q;

    // A push into a full FIFO is accepted when the head is consumed on the same edge.
    assign pop      = !empty && out_ready;
    assign push     = loadOut && (!full || pop);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    // The head register is preloaded with the next entry so the output needs no read cycle.
    always_comb begin
        head_d = head_q;
        if (push && (count_q == CW'(pop))) begin
            head_d = bus_in;
        end else if (count_q > CW'(pop)) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (loadOut && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef OUT_PORT_LAST_EN
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
        end else if (push) begin
            last_q <= bus_in;
        end
    end

    assign last_out = last_q;
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: queue model checked every cycle plus directed literal expectations.
module tb_out_port_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             loadOut = 1'b0;
    logic [WIDTH-1:0] bus_in = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             full;
    logic             empty;
    logic [2:0]       count;
    logic             overflow;
`ifdef OUT_PORT_LAST_EN
    logic [WIDTH-1:0] last_out;
`endif

    int checks = 0;
    int errors = 0;

    int mq[$];
    int ovf_m = 0;
    int last_m = 0;
    int dut_drained[$];

    out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .loadOut   (loadOut),
        .bus_in    (bus_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
`ifdef OUT_PORT_LAST_EN
        ,
        .last_out  (last_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain queue; a write is kept if there is room before or after this edge's pop.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            ovf_m  = 0;
            last_m = 0;
        end else begin
            bit p;
            bit w;
            p = (mq.size() > 0) && out_ready;
            w = loadOut && ((mq.size() < DEPTH) || p);
            if (loadOut && !w) ovf_m = 1;
            if (p) void'(mq.pop_front());
            if (w) begin
                mq.push_back(int'(bus_in));
                last_m = int'(bus_in);
            end
        end
    end

    always @(negedge clk) begin
        chk("count", int'(count), mq.size());
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("overflow", int'(overflow), ovf_m);
        if (!reset) chk("out_data_in_reset", int'(out_data), 0);
        else if (mq.size() > 0) chk("head", int'(out_data), mq[0]);
`ifdef OUT_PORT_LAST_EN
        chk("last_out", int'(last_out), last_m);
`endif
        if (reset && out_valid && out_ready) dut_drained.push_back(int'(out_data));
    end

    task automatic drv(input bit ld, input int d, input bit rdy);
        @(posedge clk);
        #2;
        loadOut   = ld;
        bus_in    = WIDTH'(d);
        out_ready = rdy;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        drv(0, 0, 1);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            #1;
            if (empty) done = 1;
        end
        drv(0, 0, 0);
        chk("drain_ends_empty", int'(empty), 1);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        reset = 1'b0;
        loadOut = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int exp_a[6];
        int exp_b[5];
        exp_a = '{1, 2, 3, 4, 5, 6};
        exp_b = '{1, 2, 3, 4, 7};

        // Reset held with a write strobe present
        reset = 1'b0;
        loadOut = 1'b1;
        bus_in = 4'hA;
        repeat (3) @(posedge clk);
        settle();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        loadOut = 1'b0;

        // Single push, then stall
        drv(1, 4'hA, 0);
        drv(0, 0, 0);
        settle();
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 4'hA);
        chk("single_count", int'(count), 1);
        repeat (5) @(posedge clk);
        settle();
        chk("stall_data", int'(out_data), 4'hA);
        drain();

        // Fill, overflow attempt, partial pop, refill, drain
        drv(1, 1, 0);
        drv(1, 2, 0);
        drv(1, 3, 0);
        drv(1, 4, 0);
        drv(0, 0, 0);
        settle();
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 4);
        drv(1, 4'hF, 0);
        drv(0, 0, 0);
        settle();
        chk("ovf_count", int'(count), 4);
        chk("ovf_flag", int'(overflow), 1);
        dut_drained.delete();
        drv(0, 0, 1);
        drv(0, 0, 1);
        drv(1, 5, 0);
        drv(1, 6, 0);
        drain();
        chk("order_len", dut_drained.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < dut_drained.size()) chk("order_word", dut_drained[i], exp_a[i]);
        end
        chk("ovf_sticky", int'(overflow), 1);

        // Simultaneous push and pop while full
        reset_pulse();
        drv(1, 1, 0);
        drv(1, 2, 0);
        drv(1, 3, 0);
        drv(1, 4, 0);
        dut_drained.delete();
        drv(1, 7, 1);
        drv(0, 0, 0);
        settle();
        chk("pp_count", int'(count), 4);
        chk("pp_overflow", int'(overflow), 0);
        drain();
        chk("pp_len", dut_drained.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_drained.size()) chk("pp_word", dut_drained[i], exp_b[i]);
        end

        // Asynchronous reset between clock edges
        drv(1, 8, 0);
        drv(1, 9, 0);
        drv(0, 0, 0);
        @(negedge clk);
        #2;
        chk("pre_async_count", int'(count), 2);
        reset = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_valid", int'(out_valid), 0);
        chk("async_data", int'(out_data), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;

`ifdef OUT_PORT_LAST_EN
        drv(1, 3, 0);
        drv(1, 9, 0);
        drv(0, 0, 0);
        settle();
        chk("last_out_lit", int'(last_out), 9);
        chk("last_head_lit", int'(out_data), 3);
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Output stage downstream of the operand bus driver and the microROM `loadOut` strobe.
- Captures each 4-bit value the CPU writes to its output port into a small first-word-fall-through FIFO.
- Presents the buffered values to an external peripheral over a valid/ready handshake.
- Decouples the CPU's one-write-per-instruction output from a slower consumer, such as a display or UART shim.

Parameters:
- WIDTH, 4, data width of the bus and of each FIFO entry.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- loadOut  input  1  write strobe from the microROM; sampled at the rising edge of clk.
- bus_in  input  WIDTH  value on the data bus, taken from the bus driver output.
- out_ready  input  1  consumer can accept the word on out_data this cycle.
- out_valid  output  1  out_data holds a valid head entry.
- out_data  output  WIDTH  head-of-FIFO word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset is asynchronous and active-low; one clock domain.
- While reset is low:
  - write pointer, read pointer and count are 0;
  - out_valid = 0, empty = 1, full = 0, overflow = 0;
  - storage contents are don't-care;
  - out_data = 0.
- Reset asserted mid-operation discards every entry immediately, without waiting for a clock edge.
- Push: loadOut == 1 at a rising edge while the FIFO is not full.
  - bus_in is written at the write pointer.
  - The write pointer increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge.
  - The read pointer increments modulo DEPTH.
- Push and pop in the same edge:
  - count is unchanged and both pointers advance.
  - This also holds when full: the push is accepted because a slot frees in the same edge.
- Push with the FIFO full and no pop:
  - the write is dropped and the storage is unchanged;
  - overflow is set to 1 and stays 1 until reset.
- Push with the FIFO empty:
  - out_valid rises on the following edge, giving 1-cycle write-to-valid latency;
  - out_data equals the written value in that same cycle.
- There is no combinational bypass from bus_in to out_data.
- First-word-fall-through: out_data is the entry at the read pointer. It is registered or read from storage, with no extra read cycle.
- out_valid = !empty.
- When empty, out_data holds its last value and must not be interpreted.
- Pop while empty cannot occur, because the pop is gated by out_valid.
- Pointer widths are $clog2(DEPTH). Wrap-around is natural overflow of the pointers.
- count is an explicit up/down counter: +1 on push only, -1 on pop only, unchanged otherwise.
- full and empty are decoded from count, not from the pointers.
- out_data must not change while out_valid == 1 and out_ready == 0. The head is stable until it is consumed.

Optional Feature:
- Macro: OUT_PORT_LAST_EN.
- When defined:
  - an extra output `last_out`, WIDTH bits, holds the most recently accepted pushed value;
  - it updates on the same edge as the push and resets to 0;
  - it is intended to drive LEDs or a 7-segment display directly, independent of FIFO draining.
- When not defined:
  - the port and its register are absent;
  - behaviour of all other ports is identical.

Test Plan:
- Reset check: hold reset low for 3 edges, with loadOut = 1 and bus_in = 4'hA. Required: count = 0, empty = 1, out_valid = 0, overflow = 0, out_data = 0.
- Single push: push 4'hA with out_ready = 0. Required: after 1 edge, out_valid = 1, out_data = 4'hA, count = 1, and out_data stays 4'hA for 5 stalled cycles.
- Order and wrap:
  - Push 4'h1, 4'h2, 4'h3, 4'h4. Required: full = 1, count = 4.
  - Pop 2, then push 4'h5, 4'h6, then drain. Required output order: 1, 2, 3, 4, 5, 6; empty = 1 at the end.
- Overflow: when full, push 4'hF with out_ready = 0. Required: the value is dropped, count stays 4, overflow = 1, and the drained data excludes 4'hF; overflow stays 1 after draining.
- Simultaneous push and pop when full: loadOut = 1 with bus_in = 4'h7 and out_ready = 1. Required: count stays 4, overflow stays 0, and 4'h7 appears as the last word drained. Also: reset low mid-stream clears count to 0 without a clock edge.
- With OUT_PORT_LAST_EN: push 4'h3, then 4'h9. Required: last_out = 4'h9 while out_data = 4'h3.
